data_mem_port: RTL

//  Responder to the controller's memory-control outputs (mem_read, mem_write, data_mem_mode).

---
 rtl/data_mem_port_if.sv | 48 ++++
 rtl/data_mem_port.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_port_if.sv
// ----------------------------------------------------------------------------
// data_mem_port_if
// Groups the core-facing memory request/response signals and the data-SRAM
// macro signals of data_mem_port into one bundle.
//
// Handshake: a request is valid when mem_read | mem_write is high. The port
// accepts it only while its FSM is idle. When stall is high in the accept
// cycle, the core must hold PC and all request inputs for one more cycle.
// When stall is low, the request is complete. A misaligned request is
// rejected in the same cycle, and misaligned pulses high for that cycle.
// An SRAM read (sram_en && !sram_we) returns sram_rdata on the next cycle.
//
// Modports
//   slave  : the data_mem_port itself
//   master : the environment (core datapath + SRAM macro)
// ----------------------------------------------------------------------------
interface data_mem_port_if #(
    parameter int ADDR_WIDTH = 10
);
    // core side
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            data_mem_mode;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  stall;
    logic                  misaligned;
    logic [31:0]           fault_addr;
    // SRAM side
    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_wdata;
    logic [31:0]           sram_rdata;

    modport slave (
        input  mem_read, mem_write, data_mem_mode, addr, wdata, sram_rdata,
        output rdata, stall, misaligned, fault_addr,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output mem_read, mem_write, data_mem_mode, addr, wdata, sram_rdata,
        input  rdata, stall, misaligned, fault_addr,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/data_mem_port.sv
// ----------------------------------------------------------------------------
// data_mem_port
// Executes LB/LH/LW/LBU/LHU/SB/SH/SW against a word-wide single-port SRAM
// that has no byte enables. The SRAM has a one-cycle read latency.
//   - SW is written in the accept cycle, with no stall.
//   - Loads read the word, then extend the selected byte/half one cycle later.
//   - SB/SH read the word, then write back the merged word one cycle later.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   bus        data_mem_port_if.slave: core request/response + SRAM macro
//   dbg_state  current FSM state (0 IDLE, 1 LD_RESP, 2 ST_MERGE)
//
// Mode encodings follow funct3:
//   loads : LB=000 LH=001 LW=010 LBU=100 LHU=101
//   stores: SB=000 SH=001 SW=010
// ----------------------------------------------------------------------------
module data_mem_port #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    data_mem_port_if.slave   bus,
    output logic [1:0]       dbg_state
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LD_RESP  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    logic [1:0]            state_q, state_d;
    logic [2:0]            mode_q, mode_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           fault_q, fault_d;

    logic       req;
    logic [2:0] eff_mode;
    logic       mis;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] merged;

    always_comb begin
        req = bus.mem_read | bus.mem_write;

        // mem_write wins when both are set. Undefined modes collapse to a
        // word access.
        if (bus.mem_write) begin
            case (bus.data_mem_mode)
                DM_B, DM_H: eff_mode = bus.data_mem_mode;
                default:    eff_mode = DM_W;
            endcase
        end else begin
            case (bus.data_mem_mode)
                DM_B, DM_H, DM_BU, DM_HU: eff_mode = bus.data_mem_mode;
                default:                  eff_mode = DM_W;
            endcase
        end

        case (eff_mode)
            DM_W:        mis = (bus.addr[1:0] != 2'b00);
            DM_H, DM_HU: mis = bus.addr[0];
            default:     mis = 1'b0;
        endcase
    end

    // Byte/half selection of the returned word by the latched offset
    always_comb begin
        case (off_q)
            2'd0:    sel_byte = bus.sram_rdata[7:0];
            2'd1:    sel_byte = bus.sram_rdata[15:8];
            2'd2:    sel_byte = bus.sram_rdata[23:16];
            default: sel_byte = bus.sram_rdata[31:24];
        endcase
        sel_half = off_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];

        merged = bus.sram_rdata;
        if (mode_q == DM_B) begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        off_d   = off_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        fault_d = fault_q;

        bus.rdata      = 32'd0;
        bus.stall      = 1'b0;
        bus.misaligned = 1'b0;
        bus.sram_en    = 1'b0;
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = 32'd0;

        // Outputs are held quiet while reset is asserted, so a reset that
        // lands on ST_MERGE never commits the merged word.
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (mis) begin
                            bus.misaligned = 1'b1;
                            fault_d        = bus.addr;
                        end else if (bus.mem_write && eff_mode == DM_W) begin
                            bus.sram_en    = 1'b1;
                            bus.sram_we    = 1'b1;
                            bus.sram_addr  = bus.addr[ADDR_WIDTH+1:2];
                            bus.sram_wdata = bus.wdata;
                        end else begin
                            bus.sram_en   = 1'b1;
                            bus.sram_addr = bus.addr[ADDR_WIDTH+1:2];
                            bus.stall     = 1'b1;
                            mode_d        = eff_mode;
                            off_d         = bus.addr[1:0];
                            idx_d         = bus.addr[ADDR_WIDTH+1:2];
                            wdata_d       = bus.wdata;
                            state_d       = bus.mem_write ? ST_MERGE : LD_RESP;
                        end
                    end
                end
                LD_RESP: begin
                    case (mode_q)
                        DM_B:    bus.rdata = {{24{sel_byte[7]}}, sel_byte};
                        DM_BU:   bus.rdata = {24'd0, sel_byte};
                        DM_H:    bus.rdata = {{16{sel_half[15]}}, sel_half};
                        DM_HU:   bus.rdata = {16'd0, sel_half};
                        default: bus.rdata = bus.sram_rdata;
                    endcase
                    state_d = IDLE;
                end
                ST_MERGE: begin
                    bus.sram_en    = 1'b1;
                    bus.sram_we    = 1'b1;
                    bus.sram_addr  = idx_q;
                    bus.sram_wdata = merged;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 3'd0;
            off_q   <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            fault_q <= 32'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
        end
    end

    assign bus.fault_addr = fault_q;
    assign dbg_state      = state_q;
endmodule
